// File: rtl/bg_fg_classify.sv
// bg_fg_classify
// ----------------------------------------------------------------------------
// Foreground/background classifier that sits directly after the background
// averaging stage. For each live RGB565 pixel and its matching background
// pixel it forms the weighted absolute difference 2*|dR| + |dG| + 2*|dB|.
// It compares that sum with a per-frame threshold and emits either a binary
// mask (mode=0) or the live pixel gated by the foreground decision (mode=1).
//
// Pipeline: 2 stages, valid/ready on both sides. Both stages advance together
// whenever the output register is empty or being drained (in_ready = adv).
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_pix, in_bg       live and background pixel (RGB565)
//   in_sof, in_eof      frame delimiters on the input beat
//   thresh              foreground threshold, latched on each accepted sof
//   mode                0 = binary mask, 1 = gated pixel (sampled at stage 2)
//   out_valid/out_ready output handshake
//   out_pix, out_fg     result pixel and foreground flag
//   out_sof, out_eof    frame delimiters travelling with the beat
//   fg_count            foreground pixels in the last completed frame
//   frame_done          one-cycle pulse when fg_count updates
//   frame_err           sticky flag: sof arrived inside an open frame
//
// Build option: define BGS_FG_STATS_EN to build the per-frame foreground
// counter. Without it, fg_count and frame_done are tied to zero.
// ----------------------------------------------------------------------------
module bg_fg_classify #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_pix,
  input  logic [15:0]      in_bg,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [7:0]       thresh,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_pix,
  output logic             out_fg,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CNT_W-1:0] fg_count,
  output logic             frame_done,
  output logic             frame_err
);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  // Absolute difference of two unsigned channel values (6-bit wide covers
  // both the 5-bit R/B and the 6-bit G channels).
  function automatic logic [5:0] abs_diff(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

  logic        adv_s;
  logic        accept_s;
  logic        keep_s;
  logic        thr_load_s;
  logic        err_set_s;
  logic [7:0]  thr_cur_s;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  thr_lat_r;
  logic        frame_err_r;

  logic [5:0]  dr_full_s;
  logic [5:0]  dg_full_s;
  logic [5:0]  db_full_s;

  logic        s1_valid_r;
  logic [4:0]  s1_dr_r;
  logic [5:0]  s1_dg_r;
  logic [4:0]  s1_db_r;
  logic [15:0] s1_pix_r;
  logic        s1_sof_r;
  logic        s1_eof_r;
  logic [7:0]  s1_thr_r;

  logic [7:0]  sum_s;
  logic        fg_s;
  logic [15:0] pix_nxt_s;

  assign adv_s     = !out_valid || out_ready;
  assign in_ready  = adv_s;
  assign accept_s  = in_valid && adv_s;
  assign frame_err = frame_err_r;

  // Frame FSM next-state: decides whether an accepted beat is kept and
  // whether it reloads the threshold or flags a nested sof.
  always_comb begin
    state_nxt_s = state_r;
    keep_s      = 1'b0;
    thr_load_s  = 1'b0;
    err_set_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        WAIT_SOF: begin
          if (in_sof) begin
            keep_s     = 1'b1;
            thr_load_s = 1'b1;
            // sof together with eof is a complete one-pixel frame
            if (in_eof) begin
              state_nxt_s = WAIT_SOF;
            end else begin
              state_nxt_s = IN_FRAME;
            end
          end else begin
            state_nxt_s = WAIT_SOF;
          end
        end
        IN_FRAME: begin
          keep_s = 1'b1;
          if (in_sof) begin
            err_set_s  = 1'b1;
            thr_load_s = 1'b1;
          end else begin
            err_set_s  = 1'b0;
          end
          if (in_eof) begin
            state_nxt_s = WAIT_SOF;
          end else begin
            state_nxt_s = IN_FRAME;
          end
        end
        default: begin
          state_nxt_s = WAIT_SOF;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Threshold that travels with this beat: the new value on a loading sof,
  // otherwise the one latched at the start of the frame.
  always_comb begin
    thr_cur_s = thr_lat_r;
    if (thr_load_s) begin
      thr_cur_s = thresh;
    end else begin
      thr_cur_s = thr_lat_r;
    end
  end

  // Per-channel absolute differences for stage 1.
  always_comb begin
    dr_full_s = abs_diff({1'b0, in_pix[15:11]}, {1'b0, in_bg[15:11]});
    dg_full_s = abs_diff(in_pix[10:5], in_bg[10:5]);
    db_full_s = abs_diff({1'b0, in_pix[4:0]}, {1'b0, in_bg[4:0]});
  end

  // FSM state, latched threshold and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= WAIT_SOF;
      thr_lat_r   <= 8'd0;
      frame_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (thr_load_s) begin
        thr_lat_r <= thresh;
      end
      if (err_set_s) begin
        frame_err_r <= 1'b1;
      end
    end
  end

  // Stage 1 register: channel differences plus the beat's side data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_dr_r    <= 5'd0;
      s1_dg_r    <= 6'd0;
      s1_db_r    <= 5'd0;
      s1_pix_r   <= 16'h0000;
      s1_sof_r   <= 1'b0;
      s1_eof_r   <= 1'b0;
      s1_thr_r   <= 8'd0;
    end else if (adv_s) begin
      // Dropped beats (outside a frame) leave a bubble rather than a beat.
      s1_valid_r <= accept_s && keep_s;
      if (accept_s) begin
        s1_dr_r  <= dr_full_s[4:0];
        s1_dg_r  <= dg_full_s;
        s1_db_r  <= db_full_s[4:0];
        s1_pix_r <= in_pix;
        s1_sof_r <= in_sof;
        s1_eof_r <= in_eof;
        s1_thr_r <= thr_cur_s;
      end
    end
  end

  // Stage 2 combinational: weighted sum (max 187, fits 8 bits) and decision.
  always_comb begin
    sum_s = {2'b00, s1_dr_r, 1'b0} + {2'b00, s1_dg_r} + {2'b00, s1_db_r, 1'b0};
    fg_s  = (sum_s > s1_thr_r);
    if (mode) begin
      if (fg_s) begin
        pix_nxt_s = s1_pix_r;
      end else begin
        pix_nxt_s = 16'h0000;
      end
    end else begin
      if (fg_s) begin
        pix_nxt_s = 16'hFFFF;
      end else begin
        pix_nxt_s = 16'h0000;
      end
    end
  end

  // Stage 2 / output register; holds while stalled by out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= 16'h0000;
      out_fg    <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_pix <= pix_nxt_s;
        out_fg  <= fg_s;
        out_sof <= s1_sof_r;
        out_eof <= s1_eof_r;
      end
    end
  end

`ifdef BGS_FG_STATS_EN
  logic             xfer_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] running_r;
  logic [CNT_W-1:0] fg_count_r;
  logic             frame_done_r;

  assign xfer_s     = out_valid && out_ready;
  assign fg_count   = fg_count_r;
  assign frame_done = frame_done_r;

  // Running count including the beat now transferring; sof restarts it and
  // the value saturates at all-ones.
  always_comb begin
    if (out_sof) begin
      cnt_base_s = {CNT_W{1'b0}};
    end else begin
      cnt_base_s = running_r;
    end
    if (out_fg && (cnt_base_s != {CNT_W{1'b1}})) begin
      cnt_next_s = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_base_s;
    end
  end

  // Frame statistics registers, updated on output transfers only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running_r    <= {CNT_W{1'b0}};
      fg_count_r   <= {CNT_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (xfer_s) begin
        if (out_eof) begin
          fg_count_r   <= cnt_next_s;
          frame_done_r <= 1'b1;
          running_r    <= {CNT_W{1'b0}};
        end else begin
          running_r <= cnt_next_s;
        end
      end
    end
  end
`else
  assign fg_count   = {CNT_W{1'b0}};
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_bg_fg_classify.sv
module tb_bg_fg_classify;

`ifdef BGS_FG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pix;
    logic        fg;
    logic        sof;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pix;
  logic [15:0] in_bg;
  logic        in_sof;
  logic        in_eof;
  logic [7:0]  thresh;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pix;
  logic        out_fg;
  logic        out_sof;
  logic        out_eof;
  logic [18:0] fg_count;
  logic        frame_done;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  beat_t sb[$];
  bit       in_frame_m = 1'b0;
  logic [7:0] thr_m    = 8'd0;
  int       run_m      = 0;
  bit       exp_done   = 1'b0;

  bg_fg_classify #(.CNT_W(19)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_bg(in_bg), .in_sof(in_sof), .in_eof(in_eof),
    .thresh(thresh), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_fg(out_fg), .out_sof(out_sof), .out_eof(out_eof),
    .fg_count(fg_count), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int fgc(input int n);
    return STATS ? n : 0;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Drive one beat, wait for acceptance, and record the expected output.
  task automatic send(input logic [15:0] p, input logic [15:0] b,
                      input logic s, input logic e, input logic [7:0] t);
    bit ok = 1'b0;
    bit keep;
    logic [7:0] thr;
    int sum;
    bit fg;
    beat_t x;
    in_pix = p; in_bg = b; in_sof = s; in_eof = e; thresh = t; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    keep = 1'b0;
    thr  = thr_m;
    if (!in_frame_m) begin
      if (s) begin
        keep = 1'b1; thr = t; thr_m = t; in_frame_m = !e;
      end
    end else begin
      keep = 1'b1;
      if (s) begin
        thr = t; thr_m = t;
      end
      if (e) in_frame_m = 1'b0;
    end
    if (keep) begin
      sum = 2 * absd(p[15:11], b[15:11]) + absd(p[10:5], b[10:5]) + 2 * absd(p[4:0], b[4:0]);
      fg  = (sum > thr);
      x.pix = mode ? (fg ? p : 16'h0000) : (fg ? 16'hFFFF : 16'h0000);
      x.fg = fg; x.sof = s; x.eof = e;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each transfer, tracks frame stats.
  always @(negedge clk) begin
    beat_t e;
    bit nd;
    int base;
    if (!rst_n) begin
      exp_done = 1'b0;
      run_m    = 0;
    end else begin
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
      nd = 1'b0;
      if (out_valid && out_ready) begin
        chk("beat_expected", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_pix", {16'd0, out_pix}, {16'd0, e.pix});
          chk("out_fg",  {31'd0, out_fg},  {31'd0, e.fg});
          chk("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
          chk("out_eof", {31'd0, out_eof}, {31'd0, e.eof});
          base = e.sof ? 0 : run_m;
          base = base + (e.fg ? 1 : 0);
          if (e.eof) begin
            nd = 1'b1; run_m = 0;
          end else begin
            run_m = base;
          end
        end
      end
      exp_done = nd & STATS;
    end
  end

  initial begin
    logic [17:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_pix = 16'h0; in_bg = 16'h0;
    in_sof = 1'b0; in_eof = 1'b0; thresh = 8'd0; mode = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pix", {16'd0, out_pix}, 32'd0);
    chk("rst_fg_count", {13'd0, fg_count}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and threshold boundary (sum = 62)
    send(16'hF800, 16'h0000, 1'b1, 1'b1, 8'd61);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_fg61", {31'd0, out_fg}, 32'd1);
    chk("lat_pix61", {16'd0, out_pix}, 32'h0000FFFF);
    drain();
    send(16'hF800, 16'h0000, 1'b1, 1'b1, 8'd62);
    @(posedge clk); #1;
    chk("thr62_fg", {31'd0, out_fg}, 32'd0);
    chk("thr62_pix", {16'd0, out_pix}, 32'd0);
    drain();

    // Gated mode
    mode = 1'b1;
    send(16'h07E0, 16'h0000, 1'b1, 1'b1, 8'd10);
    send(16'h07E0, 16'h07E0, 1'b1, 1'b1, 8'd10);
    drain();
    mode = 1'b0;

    // Frame statistics: fg pattern 1,0,1,1 then all background
    send(16'hF800, 16'h0000, 1'b1, 1'b0, 8'd20);
    send(16'h1234, 16'h1234, 1'b0, 1'b0, 8'd20);
    send(16'hF800, 16'h0000, 1'b0, 1'b0, 8'd20);
    send(16'h001F, 16'h0000, 1'b0, 1'b1, 8'd20);
    drain();
    chk("stats_fg3", {13'd0, fg_count}, fgc(3));
    send(16'h0000, 16'h0000, 1'b1, 1'b0, 8'd20);
    send(16'h5555, 16'h5555, 1'b0, 1'b1, 8'd20);
    drain();
    chk("stats_fg0", {13'd0, fg_count}, fgc(0));

    // Backpressure with a full pipeline
    out_ready = 1'b0;
    send(16'hF800, 16'h0000, 1'b1, 1'b0, 8'd20);
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 8'd20);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    held = {out_pix, out_fg, out_eof};
    chk("bp_first_fg", {31'd0, out_fg}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {14'd0, out_pix, out_fg, out_eof}, {14'd0, held});
    end
    out_ready = 1'b1;
    send(16'hF800, 16'h0000, 1'b0, 1'b1, 8'd20);
    drain();
    chk("bp_fg2", {13'd0, fg_count}, fgc(2));

    // Beats before any sof are discarded
    for (int i = 0; i < 3; i++) send(16'hF800, 16'h0000, 1'b0, 1'b0, 8'd20);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("nosof_no_out", {31'd0, out_valid}, 32'd0);
    end
    chk("err_clear", {31'd0, frame_err}, 32'd0);

    // sof inside a frame: restart count and reload threshold (62)
    send(16'hF800, 16'h0000, 1'b1, 1'b0, 8'd20);
    send(16'hF800, 16'h0000, 1'b0, 1'b0, 8'd20);
    send(16'h07E0, 16'h0000, 1'b1, 1'b0, 8'd62);
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0);
    send(16'h001F, 16'h0000, 1'b0, 1'b1, 8'd0);
    drain();
    chk("err_set", {31'd0, frame_err}, 32'd1);
    chk("restart_fg1", {13'd0, fg_count}, fgc(1));

    // Reset with two beats in flight
    send(16'hF800, 16'h0000, 1'b1, 1'b0, 8'd20);
    send(16'hF800, 16'h0000, 1'b0, 1'b0, 8'd20);
    rst_n = 1'b0;
    sb.delete();
    in_frame_m = 1'b0;
    thr_m = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_done", {31'd0, frame_done}, 32'd0);
    chk("rstmid_err", {31'd0, frame_err}, 32'd0);
    chk("rstmid_cnt", {13'd0, fg_count}, 32'd0);
    send(16'hF800, 16'h0000, 1'b1, 1'b0, 8'd20);
    send(16'h07E0, 16'h0000, 1'b0, 1'b1, 8'd20);
    drain();
    chk("rstmid_fg2", {13'd0, fg_count}, fgc(2));

    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
